retry_phy_reinit_ctrl: RTL and testbench

RETRY_PHY_REINIT_CTRL -- requirements
Module: retry_phy_reinit_ctrl

---
 rtl/retry_phy_reinit_ctrl_pkg.sv | 26 ++
 rtl/retry_phy_reinit_ctrl_if.sv | 37 +++
 rtl/phy_reinit_timer.sv | 36 +++
 rtl/retry_phy_reinit_ctrl.sv | 128 ++++++++++++
 tb/tb_retry_phy_reinit_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/retry_phy_reinit_ctrl_pkg.sv
// ============================================================================
// Module   : retry_pkg
// Brief    : Shared state encoding and default limits for the PHY reinit
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package retry_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_LINK_FAIL = 2'd3
  } state_t;

  // Number of reinit attempts allowed before declaring link failure
  localparam logic [4:0]  DEFAULT_MAX_NUM_PHY_REINIT    = 5'd10;
  // Watchdog limit while waiting for reinit completion
  localparam logic [15:0] DEFAULT_REINIT_TIMEOUT_CYCLES = 16'd4096;

endpackage

`default_nettype wire

// File: rtl/retry_phy_reinit_ctrl_if.sv
// ============================================================================
// Module   : retry_phy_reinit_ctrl_if
// Brief    : Request/handshake bundle between retry logic, PHY and the
//            reinit controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface retry_phy_reinit_ctrl_if;
  logic       i_retry_limit_reached;
  logic [4:0] i_retry_num_phy_reinit;
  logic       i_phy_reinit_ack;
  logic       i_phy_reinit_done;
  logic       o_phy_reinit_req;
  logic       o_num_phy_reinit_inc_en;
  logic       o_num_retry_reset;
  logic       o_link_failure;
  logic       o_busy;

  // Environment side: drives requests/handshakes, observes controller outputs
  modport master (
    output i_retry_limit_reached, i_retry_num_phy_reinit,
           i_phy_reinit_ack, i_phy_reinit_done,
    input  o_phy_reinit_req, o_num_phy_reinit_inc_en,
           o_num_retry_reset, o_link_failure, o_busy
  );

  // Controller side
  modport slave (
    input  i_retry_limit_reached, i_retry_num_phy_reinit,
           i_phy_reinit_ack, i_phy_reinit_done,
    output o_phy_reinit_req, o_num_phy_reinit_inc_en,
           o_num_retry_reset, o_link_failure, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/phy_reinit_timer.sv
// ============================================================================
// Module   : phy_reinit_timer
// Brief    : Watchdog counter; flags expiry after LIMIT enabled cycles
//            since the last clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phy_reinit_timer #(
  parameter logic [15:0] LIMIT = 16'd4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] r_count;

  // Expiry is seen during the LIMIT-th enabled cycle so the owner can act
  // on the following edge.
  assign expired = enable && (r_count == (LIMIT - 16'd1));

  // Count enabled cycles; clear has priority and saturates at expiry
  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      r_count <= 16'd0;
    end else if (enable && !expired) begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/retry_phy_reinit_ctrl.sv
// ============================================================================
// Module   : retry_phy_reinit_ctrl
// Brief    : Issues PHY reinit requests when the local retry limit is hit,
//            tracks attempts and declares sticky link failure once the
//            attempt budget is exhausted.
// Options  : PHY_REINIT_TIMEOUT_EN - adds a WAIT_DONE watchdog that retries
//            (or fails) when the PHY never reports completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retry_phy_reinit_ctrl
  import retry_pkg::*;
#(
  parameter logic [4:0]  MAX_NUM_PHY_REINIT    = DEFAULT_MAX_NUM_PHY_REINIT,
  parameter logic [15:0] REINIT_TIMEOUT_CYCLES = DEFAULT_REINIT_TIMEOUT_CYCLES
) (
  input logic                     i_clk,
  input logic                     i_rst,
  retry_phy_reinit_ctrl_if.slave  bus
);

  state_t r_state;
  state_t w_next_state;
  logic   w_budget_spent;
  logic   w_inc_en;
  logic   w_retry_reset;
  logic   r_phy_reinit_req;
  logic   r_inc_en;
  logic   r_retry_reset;
  logic   r_link_failure;
  logic   r_busy;

  // Unsigned 5-bit compare on the live attempt count
  assign w_budget_spent = (bus.i_retry_num_phy_reinit >= MAX_NUM_PHY_REINIT);

`ifdef PHY_REINIT_TIMEOUT_EN
  logic w_wd_expired;

  // Watchdog runs only in WAIT_DONE and is held clear everywhere else,
  // so each WAIT_DONE entry starts from zero.
  phy_reinit_timer #(
    .LIMIT (REINIT_TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (r_state != ST_WAIT_DONE),
    .enable  (r_state == ST_WAIT_DONE),
    .expired (w_wd_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^REINIT_TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and pulse requests; inputs outside their state are ignored
  always_comb begin
    w_next_state  = r_state;
    w_inc_en      = 1'b0;
    w_retry_reset = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_retry_limit_reached) begin
          w_next_state = w_budget_spent ? ST_LINK_FAIL : ST_REQ;
        end
      end
      ST_REQ: begin
        // A simultaneous done is not consumed here
        if (bus.i_phy_reinit_ack) begin
          w_next_state = ST_WAIT_DONE;
          w_inc_en     = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.i_phy_reinit_done) begin
          w_next_state  = ST_IDLE;
          w_retry_reset = 1'b1;
        end
`ifdef PHY_REINIT_TIMEOUT_EN
        else if (w_wd_expired) begin
          w_next_state = w_budget_spent ? ST_LINK_FAIL : ST_REQ;
        end
`endif
      end
      ST_LINK_FAIL: begin
        w_next_state = ST_LINK_FAIL;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs registered from the next state so they line up with the state change
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phy_reinit_req <= 1'b0;
      r_inc_en         <= 1'b0;
      r_retry_reset    <= 1'b0;
      r_link_failure   <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_phy_reinit_req <= (w_next_state == ST_REQ);
      r_inc_en         <= w_inc_en;
      r_retry_reset    <= w_retry_reset;
      r_link_failure   <= (w_next_state == ST_LINK_FAIL);
      r_busy           <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.o_phy_reinit_req        = r_phy_reinit_req;
  assign bus.o_num_phy_reinit_inc_en = r_inc_en;
  assign bus.o_num_retry_reset       = r_retry_reset;
  assign bus.o_link_failure          = r_link_failure;
  assign bus.o_busy                  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_retry_phy_reinit_ctrl.sv
// ============================================================================
// Module   : tb_retry_phy_reinit_ctrl
// Brief    : Directed self-checking bench for retry_phy_reinit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retry_phy_reinit_ctrl;

  logic i_clk;
  logic i_rst;
  int   pass_cnt;
  int   total_cnt;

  retry_phy_reinit_ctrl_if bus ();

  retry_phy_reinit_ctrl #(
    .MAX_NUM_PHY_REINIT    (5'd10),
    .REINIT_TIMEOUT_CYCLES (16'd8)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    bus.i_retry_limit_reached  = 1'b0;
    bus.i_retry_num_phy_reinit = 5'd0;
    bus.i_phy_reinit_ack       = 1'b0;
    bus.i_phy_reinit_done      = 1'b0;

    // Reset state
    i_rst = 1'b1;
    tick();
    tick();
    chk("rst_req",  bus.o_phy_reinit_req, 1'b0);
    chk("rst_inc",  bus.o_num_phy_reinit_inc_en, 1'b0);
    chk("rst_rr",   bus.o_num_retry_reset, 1'b0);
    chk("rst_lf",   bus.o_link_failure, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    i_rst = 1'b0;
    tick();

    // Normal sequence, count=3, ack after 5 cycles of request
    bus.i_retry_num_phy_reinit = 5'd3;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    chk("seq_req",  bus.o_phy_reinit_req, 1'b1);
    chk("seq_busy", bus.o_busy, 1'b1);
    chk("seq_inc0", bus.o_num_phy_reinit_inc_en, 1'b0);
    bus.i_retry_limit_reached = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_req_hold", bus.o_phy_reinit_req, 1'b1);
      chk("seq_inc_hold", bus.o_num_phy_reinit_inc_en, 1'b0);
    end
    bus.i_phy_reinit_ack = 1'b1;
    tick();
    chk("ack_req_drop", bus.o_phy_reinit_req, 1'b0);
    chk("ack_inc",      bus.o_num_phy_reinit_inc_en, 1'b1);
    chk("ack_busy",     bus.o_busy, 1'b1);
    bus.i_phy_reinit_ack = 1'b0;
    tick();
    chk("inc_one_cycle", bus.o_num_phy_reinit_inc_en, 1'b0);
    chk("wait_busy",     bus.o_busy, 1'b1);
    bus.i_phy_reinit_done = 1'b1;
    tick();
    chk("done_rr",   bus.o_num_retry_reset, 1'b1);
    chk("done_busy", bus.o_busy, 1'b0);
    bus.i_phy_reinit_done = 1'b0;
    tick();
    chk("rr_one_cycle", bus.o_num_retry_reset, 1'b0);
    chk("idle_busy",    bus.o_busy, 1'b0);

    // Stray ack and done in IDLE
    bus.i_phy_reinit_ack  = 1'b1;
    bus.i_phy_reinit_done = 1'b1;
    tick();
    chk("stray_busy", bus.o_busy, 1'b0);
    chk("stray_req",  bus.o_phy_reinit_req, 1'b0);
    chk("stray_inc",  bus.o_num_phy_reinit_inc_en, 1'b0);
    chk("stray_rr",   bus.o_num_retry_reset, 1'b0);
    bus.i_phy_reinit_ack  = 1'b0;
    bus.i_phy_reinit_done = 1'b0;

    // Limit pulse during WAIT_DONE is ignored
    bus.i_retry_num_phy_reinit = 5'd2;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    bus.i_retry_limit_reached = 1'b0;
    bus.i_phy_reinit_ack      = 1'b1;
    tick();
    bus.i_phy_reinit_ack = 1'b0;
    tick();
    chk("in_wait_busy", bus.o_busy, 1'b1);
    bus.i_retry_limit_reached = 1'b1;
    tick();
    chk("wlim_req",  bus.o_phy_reinit_req, 1'b0);
    chk("wlim_busy", bus.o_busy, 1'b1);
    chk("wlim_lf",   bus.o_link_failure, 1'b0);
    chk("wlim_inc",  bus.o_num_phy_reinit_inc_en, 1'b0);
    bus.i_retry_limit_reached = 1'b0;

    // Reset during WAIT_DONE aborts without a retry_reset pulse
    i_rst = 1'b1;
    tick();
    chk("rstw_busy", bus.o_busy, 1'b0);
    chk("rstw_rr",   bus.o_num_retry_reset, 1'b0);
    chk("rstw_req",  bus.o_phy_reinit_req, 1'b0);
    i_rst = 1'b0;
    tick();
    chk("rstw_rr_after",   bus.o_num_retry_reset, 1'b0);
    chk("rstw_busy_after", bus.o_busy, 1'b0);

    // Ack and done together in REQ: ack only, later done needed
    bus.i_retry_num_phy_reinit = 5'd1;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    bus.i_retry_limit_reached = 1'b0;
    bus.i_phy_reinit_ack      = 1'b1;
    bus.i_phy_reinit_done     = 1'b1;
    tick();
    chk("ad_inc",  bus.o_num_phy_reinit_inc_en, 1'b1);
    chk("ad_rr",   bus.o_num_retry_reset, 1'b0);
    chk("ad_busy", bus.o_busy, 1'b1);
    bus.i_phy_reinit_ack  = 1'b0;
    bus.i_phy_reinit_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ad_wait_busy", bus.o_busy, 1'b1);
      chk("ad_wait_rr",   bus.o_num_retry_reset, 1'b0);
    end
    bus.i_phy_reinit_done = 1'b1;
    tick();
    chk("ad_done_rr",   bus.o_num_retry_reset, 1'b1);
    chk("ad_done_busy", bus.o_busy, 1'b0);
    bus.i_phy_reinit_done = 1'b0;
    tick();

    // Boundary: count=9 is below MAX=10
    bus.i_retry_num_phy_reinit = 5'd9;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    chk("cnt9_req", bus.o_phy_reinit_req, 1'b1);
    chk("cnt9_lf",  bus.o_link_failure, 1'b0);
    bus.i_retry_limit_reached = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();

    // Unsigned compare: count=31 fails
    bus.i_retry_num_phy_reinit = 5'd31;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    chk("cnt31_lf",  bus.o_link_failure, 1'b1);
    chk("cnt31_req", bus.o_phy_reinit_req, 1'b0);
    bus.i_retry_limit_reached = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();

    // Count=10 -> LINK_FAIL, sticky against all inputs until reset
    bus.i_retry_num_phy_reinit = 5'd10;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    chk("lf_set",  bus.o_link_failure, 1'b1);
    chk("lf_req",  bus.o_phy_reinit_req, 1'b0);
    chk("lf_busy", bus.o_busy, 1'b1);
    bus.i_retry_num_phy_reinit = 5'd3;
    bus.i_phy_reinit_ack       = 1'b1;
    bus.i_phy_reinit_done      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lf_sticky", bus.o_link_failure, 1'b1);
      chk("lf_noreq",  bus.o_phy_reinit_req, 1'b0);
      chk("lf_noinc",  bus.o_num_phy_reinit_inc_en, 1'b0);
      chk("lf_norr",   bus.o_num_retry_reset, 1'b0);
    end
    bus.i_retry_limit_reached = 1'b0;
    bus.i_phy_reinit_ack      = 1'b0;
    bus.i_phy_reinit_done     = 1'b0;
    i_rst = 1'b1;
    tick();
    chk("lf_cleared",  bus.o_link_failure, 1'b0);
    chk("lf_rst_busy", bus.o_busy, 1'b0);
    i_rst = 1'b0;
    tick();

`ifdef PHY_REINIT_TIMEOUT_EN
    // Watchdog: 8 cycles in WAIT_DONE without done -> new request
    bus.i_retry_num_phy_reinit = 5'd4;
    bus.i_retry_limit_reached  = 1'b1;
    tick();
    bus.i_retry_limit_reached = 1'b0;
    bus.i_phy_reinit_ack      = 1'b1;
    tick();
    bus.i_phy_reinit_ack = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("wd_before_req",  bus.o_phy_reinit_req, 1'b0);
    chk("wd_before_busy", bus.o_busy, 1'b1);
    tick();
    chk("wd_rereq", bus.o_phy_reinit_req, 1'b1);
    bus.i_phy_reinit_ack = 1'b1;
    tick();
    chk("wd_reinc", bus.o_num_phy_reinit_inc_en, 1'b1);
    bus.i_phy_reinit_ack       = 1'b0;
    bus.i_retry_num_phy_reinit = 5'd10;
    for (int i = 0; i < 7; i++) tick();
    chk("wd_before_lf", bus.o_link_failure, 1'b0);
    tick();
    chk("wd_lf",     bus.o_link_failure, 1'b1);
    chk("wd_lf_req", bus.o_phy_reinit_req, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
